branch_history_table: RTL and testbench
=======================================

Name: branch_history_table

Overview:
- Dynamic replacement for the static backward-taken/forward-not-taken branch predictor.
- Holds a direct-mapped table of 2-bit saturating counters indexed by PC.
- Produces a fetch-stage taken prediction and accepts resolved-branch updates from execute.
- An internal init FSM sweeps the table after reset; the static rule is used until the sweep completes.

Parameters:
- XLEN, 32, address/data width.
- INDEX_BITS, 6, log2 of table entries (default 64 entries).
- INIT_STATE, 2'b01, counter value written to every entry during init (weakly not-taken).

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous, active-high reset.
- pc  input  XLEN  fetch PC of the instruction being predicted.
- branch_target  input  XLEN  computed target, used only by the static fallback.
- jump  input  1  instruction is JAL/JALR.
- branch  input  1  instruction is a conditional branch.
- branch_predicted_taken  output  1  prediction (combinational).
- init_done  output  1  table sweep complete; dynamic prediction active.
- update_valid  input  1  execute stage resolved a conditional branch this cycle.
- update_pc  input  XLEN  PC of the resolved branch.
- update_taken  input  1  actual outcome of the resolved branch.

Behaviour:
- Index derivation: idx = pc[INDEX_BITS+1:2]; update index uses the same bits of update_pc. PC bits [1:0] are ignored.
- FSM states:
  - INIT: a sweep counter of INDEX_BITS+1 bits walks the table.
  - RUN: normal operation.
- Reset:
  - reset=1 at a clock edge forces state=INIT, sweep counter=0, init_done=0.
  - Table contents are not cleared by reset directly; the sweep rewrites them.
  - Reset mid-INIT or mid-RUN restarts the sweep from index 0.
- INIT:
  - Each cycle writes INIT_STATE to entry[sweep], then increments sweep.
  - After entry 2^INDEX_BITS-1 is written, state goes to RUN on that edge.
  - init_done=1 from the next cycle. The sweep takes exactly 2^INDEX_BITS cycles after reset deasserts.
  - update_valid is ignored (dropped) in INIT.
- RUN:
  - When update_valid=1, entry[update_idx] saturates: taken increments (11 stays 11); not-taken decrements (00 stays 00).
  - The write takes effect at the clock edge.
- Prediction (combinational, every cycle):
  - jump=1 -> 1, regardless of state.
  - else branch=1 and state=RUN -> entry[idx][1].
  - else branch=1 and state=INIT -> (branch_target < pc), unsigned compare.
  - else -> 0.
- Simultaneous lookup and update to the same index: the prediction uses the pre-update counter value (read-before-write, no bypass).
- Simultaneous updates to different indices are not possible (single update port).
- Outputs during reset=1: init_done=0; prediction follows the INIT rule.

Decomposition:
- Shared package holds:
  - 2-bit counter typedef (bht_ctr_t).
  - Constants STRONG_NT=2'b00, WEAK_NT=2'b01, WEAK_T=2'b10, STRONG_T=2'b11.
  - FSM state enum {BHT_INIT, BHT_RUN}.
- One sub-module: sat_counter_2b, a pure combinational next-value function (ctr, taken -> ctr_next), reused by the future tournament predictor.
- The table array, sweep counter and FSM stay in branch_history_table.

Test Plan:
1. Init sweep and static fallback.
   - Stimulus: reset 1 cycle, then count cycles.
   - Required: init_done=0 for exactly 64 cycles and 1 on cycle 65.
   - During INIT: branch=1, pc=0x100, branch_target=0x80 -> 1; branch_target=0x200 -> 0.
2. Post-init default.
   - Stimulus: after init, branch=1 at any pc, e.g. 0x40.
   - Required: predict 0 (WEAK_NT). jump=1 -> 1; branch=jump=0 -> 0.
3. Training and saturation.
   - Stimulus: three updates taken at update_pc=0x40.
   - Required: prediction at pc=0x40 becomes 1 after the first update; the counter saturates at 11.
   - Then: one not-taken -> still 1; second not-taken -> 0.
4. Aliasing and index isolation.
   - Stimulus: train 0x40 taken.
   - Required: pc=0x44 still predicts 0; pc=0x140 (same idx with INDEX_BITS=6) predicts 1.
5. Same-cycle read/write.
   - Stimulus: pc=update_pc=0x80, counter 01, update_taken=1.
   - Required: the prediction that cycle is 0; the next cycle it is 1.
6. Reset mid-operation.
   - Stimulus: train 0x40 to 11, assert reset for 1 cycle.
   - Required: init_done drops and the 64-cycle sweep reruns.
   - update_valid pulses during the sweep are dropped.
   - Afterwards pc=0x40 predicts 0.

Source files
------------

// File: rtl/branch_history_table_pkg.sv
// Shared types and constants for the branch history table and related predictors.
//   bht_ctr_t    : 2-bit saturating counter value.
//   STRONG_NT..  : named counter encodings.
//   bht_state_e  : table lifecycle (sweeping after reset, or running).
//   ctr_taken    : helper returning the taken decision encoded by a counter.
package branch_history_table_pkg;

  typedef logic [1:0] bht_ctr_t;

  localparam bht_ctr_t STRONG_NT = 2'b00;
  localparam bht_ctr_t WEAK_NT   = 2'b01;
  localparam bht_ctr_t WEAK_T    = 2'b10;
  localparam bht_ctr_t STRONG_T  = 2'b11;

  typedef enum logic {
    BHT_INIT,
    BHT_RUN
  } bht_state_e;

  // The MSB of a 2-bit counter is the taken/not-taken decision.
  function automatic logic ctr_taken(input bht_ctr_t ctr);
    return ctr[1];
  endfunction

endpackage

// File: rtl/sat_counter_2b.sv
// Combinational next-value function of a 2-bit saturating counter.
//   i_ctr      : current counter value.
//   i_taken    : resolved outcome; 1 counts up, 0 counts down.
//   o_ctr_next : updated value, clamped at STRONG_NT and STRONG_T.
module sat_counter_2b
  import branch_history_table_pkg::*;
(
  input  logic [1:0] i_ctr,
  input  logic       i_taken,
  output logic [1:0] o_ctr_next
);

  always_comb begin
    o_ctr_next = i_ctr;
    if (i_taken) begin
      if (i_ctr != STRONG_T) o_ctr_next = i_ctr + 2'b01;
    end else begin
      if (i_ctr != STRONG_NT) o_ctr_next = i_ctr - 2'b01;
    end
  end

endmodule

// File: rtl/branch_history_table.sv
// Direct-mapped table of 2-bit saturating counters giving a fetch-stage taken prediction.
// After reset an init sweep rewrites every entry with INIT_STATE; until it completes the
// static backward-taken/forward-not-taken rule is used.
//   i_clk, i_reset            : clock, synchronous active-high reset.
//   i_pc, i_branch_target     : fetch PC and computed target (target only used by static rule).
//   i_jump, i_branch          : instruction class of the fetched instruction.
//   o_branch_predicted_taken  : combinational prediction.
//   o_init_done               : sweep finished, dynamic prediction active.
//   i_update_valid/_pc/_taken : resolved conditional branch from execute.
module branch_history_table
  import branch_history_table_pkg::*;
#(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned INDEX_BITS = 6,
  parameter logic [1:0]  INIT_STATE = 2'b01
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic [XLEN-1:0] i_pc,
  input  logic [XLEN-1:0] i_branch_target,
  input  logic            i_jump,
  input  logic            i_branch,
  output logic            o_branch_predicted_taken,
  output logic            o_init_done,
  input  logic            i_update_valid,
  input  logic [XLEN-1:0] i_update_pc,
  input  logic            i_update_taken
);

  localparam int unsigned Entries = 1 << INDEX_BITS;
  localparam logic [INDEX_BITS:0] SweepLast = (INDEX_BITS + 1)'(Entries - 1);

  bht_ctr_t             r_table [Entries];
  bht_state_e           r_state;
  bht_state_e           w_state_next;
  logic [INDEX_BITS:0]  r_sweep;
  logic [INDEX_BITS:0]  w_sweep_next;

  logic [INDEX_BITS-1:0] w_rd_idx;
  logic [INDEX_BITS-1:0] w_upd_idx;
  bht_ctr_t              w_rd_ctr;
  bht_ctr_t              w_upd_ctr;
  bht_ctr_t              w_upd_next;
  logic                  w_run;

  logic                  w_wr_en;
  logic [INDEX_BITS-1:0] w_wr_idx;
  bht_ctr_t              w_wr_data;

  // PC bits outside the index field do not participate in the lookup.
  logic w_unused_pc;
  assign w_unused_pc = ^{i_pc[XLEN-1:INDEX_BITS+2], i_pc[1:0],
                         i_update_pc[XLEN-1:INDEX_BITS+2], i_update_pc[1:0]};

  assign w_rd_idx  = i_pc[INDEX_BITS+1:2];
  assign w_upd_idx = i_update_pc[INDEX_BITS+1:2];
  assign w_rd_ctr  = r_table[w_rd_idx];
  assign w_upd_ctr = r_table[w_upd_idx];

  sat_counter_2b u_upd_ctr (
    .i_ctr      (w_upd_ctr),
    .i_taken    (i_update_taken),
    .o_ctr_next (w_upd_next)
  );

  // Reset forces the static rule immediately, not only from the next edge.
  assign w_run       = (r_state == BHT_RUN) && !i_reset;
  assign o_init_done = w_run;

  // Next-state and single table write port: sweep in INIT, training updates in RUN.
  always_comb begin
    w_state_next = r_state;
    w_sweep_next = r_sweep;
    w_wr_en      = 1'b0;
    w_wr_idx     = w_upd_idx;
    w_wr_data    = w_upd_next;
    unique case (r_state)
      BHT_INIT: begin
        w_wr_en      = 1'b1;
        w_wr_idx     = r_sweep[INDEX_BITS-1:0];
        w_wr_data    = INIT_STATE;
        w_sweep_next = r_sweep + 1'b1;
        if (r_sweep == SweepLast) w_state_next = BHT_RUN;
      end
      BHT_RUN: begin
        w_wr_en = i_update_valid;
      end
      default: begin
        w_state_next = BHT_INIT;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= BHT_INIT;
      r_sweep <= '0;
    end else begin
      r_state <= w_state_next;
      r_sweep <= w_sweep_next;
    end
  end

  // Table storage has no reset; the sweep is what initialises it.
  always_ff @(posedge i_clk) begin
    if (!i_reset && w_wr_en) r_table[w_wr_idx] <= w_wr_data;
  end

  // Read-before-write: lookup sees the counter value from before any same-cycle update.
  always_comb begin
    o_branch_predicted_taken = 1'b0;
    if (i_jump) begin
      o_branch_predicted_taken = 1'b1;
    end else if (i_branch) begin
      if (w_run) o_branch_predicted_taken = ctr_taken(w_rd_ctr);
      else       o_branch_predicted_taken = (i_branch_target < i_pc);
    end
  end

endmodule

// File: tb/tb_branch_history_table.sv
module tb_branch_history_table;

  localparam int Entries = 64;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc, target, upd_pc;
  logic        jump, branch, upd_valid, upd_taken;
  logic        pred, init_done;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model: counters as plain integers in 0..3, sweep as a cycle count.
  int m_tab [Entries];
  bit m_run;
  int m_sweep;

  branch_history_table dut (
    .i_clk                    (clk),
    .i_reset                  (reset),
    .i_pc                     (pc),
    .i_branch_target          (target),
    .i_jump                   (jump),
    .i_branch                 (branch),
    .o_branch_predicted_taken (pred),
    .o_init_done              (init_done),
    .i_update_valid           (upd_valid),
    .i_update_pc              (upd_pc),
    .i_update_taken           (upd_taken)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  function automatic logic model_pred();
    if (jump) return 1'b1;
    if (branch) begin
      if (m_run && !reset) return (m_tab[(pc / 4) % Entries] >= 2);
      return (target < pc);
    end
    return 1'b0;
  endfunction

  // One clock: check outputs before the edge, then advance the model at the edge.
  task automatic tick();
    bit          s_rst, s_uv, s_ut;
    logic [31:0] s_upc;
    int          k;
    #1;
    check("pred", pred, model_pred());
    check("init_done", init_done, m_run && !reset);
    s_rst = reset; s_uv = upd_valid; s_ut = upd_taken; s_upc = upd_pc;
    @(posedge clk);
    if (s_rst) begin
      m_run = 0; m_sweep = 0;
    end else if (!m_run) begin
      m_tab[m_sweep] = 1;
      m_sweep++;
      if (m_sweep == Entries) m_run = 1;
    end else if (s_uv) begin
      k = (s_upc / 4) % Entries;
      if (s_ut) m_tab[k] = (m_tab[k] == 3) ? 3 : m_tab[k] + 1;
      else      m_tab[k] = (m_tab[k] == 0) ? 0 : m_tab[k] - 1;
    end
    @(negedge clk);
  endtask

  task automatic expect_pred(input string tag, input logic exp);
    #1;
    check(tag, pred, exp);
  endtask

  task automatic set_fetch(input logic [31:0] p, input logic [31:0] t, input logic b,
                           input logic j);
    pc = p; target = t; branch = b; jump = j;
  endtask

  task automatic set_upd(input logic v, input logic [31:0] p, input logic t);
    upd_valid = v; upd_pc = p; upd_taken = t;
  endtask

  // Hold reset one cycle, then count cycles until init_done rises with noisy inputs.
  task automatic reset_and_sweep(input string tag);
    int n;
    reset = 1'b1;
    set_fetch(32'h100, 32'h80, 1'b1, 1'b0);
    tick();
    reset = 1'b0;
    n = 0;
    while (!init_done && n < 200) begin
      set_fetch(32'h100, (n < 32) ? 32'h80 : 32'h200, 1'b1, 1'b0);
      if (n == 3) expect_pred({tag, "_static_bwd"}, 1'b1);
      if (n == 40) expect_pred({tag, "_static_fwd"}, 1'b0);
      set_upd($urandom_range(0, 1) == 1, 32'h40, 1'b1);
      tick();
      n++;
    end
    n_cmp++;
    assert (n === Entries) else begin
      n_fail++;
      $error("FAIL %s_sweep_cycles observed=%0d expected=%0d", tag, n, Entries);
    end
    set_upd(1'b0, 32'h0, 1'b0);
  endtask

  initial begin
    m_run = 0; m_sweep = 0;
    foreach (m_tab[i]) m_tab[i] = 0;
    reset = 1'b0;
    set_fetch(32'h0, 32'h0, 1'b0, 1'b0);
    set_upd(1'b0, 32'h0, 1'b0);
    @(negedge clk);

    // 1. Init sweep with static fallback and dropped updates.
    reset_and_sweep("init");

    // 2. Post-init default.
    set_fetch(32'h40, 32'h0, 1'b1, 1'b0);
    expect_pred("post_init_weak_nt", 1'b0);
    tick();
    set_fetch(32'h40, 32'h0, 1'b1, 1'b1);
    expect_pred("jump", 1'b1);
    tick();
    set_fetch(32'h40, 32'h0, 1'b0, 1'b0);
    expect_pred("no_branch", 1'b0);
    tick();

    // 3. Training and saturation at 0x40.
    set_fetch(32'h40, 32'h0, 1'b1, 1'b0);
    set_upd(1'b1, 32'h40, 1'b1);
    tick();
    expect_pred("train_first", 1'b1);
    tick();
    tick();
    set_upd(1'b0, 32'h0, 1'b0);
    tick();
    set_upd(1'b1, 32'h40, 1'b0);
    tick();
    expect_pred("nt_once_still_taken", 1'b1);
    tick();
    set_upd(1'b0, 32'h0, 1'b0);
    expect_pred("nt_twice", 1'b0);
    tick();

    // 4. Aliasing and index isolation.
    set_upd(1'b1, 32'h40, 1'b1);
    tick();
    set_upd(1'b0, 32'h0, 1'b0);
    set_fetch(32'h44, 32'h0, 1'b1, 1'b0);
    expect_pred("neighbour_idx", 1'b0);
    tick();
    set_fetch(32'h140, 32'h0, 1'b1, 1'b0);
    expect_pred("alias_idx", 1'b1);
    tick();

    // 5. Same-cycle lookup and update.
    set_fetch(32'h80, 32'h0, 1'b1, 1'b0);
    set_upd(1'b1, 32'h80, 1'b1);
    expect_pred("rbw_same_cycle", 1'b0);
    tick();
    set_upd(1'b0, 32'h0, 1'b0);
    expect_pred("rbw_next_cycle", 1'b1);
    tick();

    // 6. Reset mid-operation after saturating 0x40.
    set_fetch(32'h40, 32'h0, 1'b1, 1'b0);
    set_upd(1'b1, 32'h40, 1'b1);
    repeat (3) tick();
    set_upd(1'b0, 32'h0, 1'b0);
    reset = 1'b1;
    #1;
    check("init_done_in_reset", init_done, 1'b0);
    reset = 1'b0;
    reset_and_sweep("rerun");
    set_fetch(32'h40, 32'h0, 1'b1, 1'b0);
    expect_pred("after_reset_default", 1'b0);
    tick();

    // Randomized phase with occasional resets, checked against the model each cycle.
    for (int i = 0; i < 1500; i++) begin
      reset = ($urandom_range(0, 299) == 0);
      pc = ($urandom_range(0, 3) << 8) | ($urandom_range(0, 7) << 2) | $urandom_range(0, 3);
      target = $urandom_range(0, 1023);
      branch = ($urandom_range(0, 3) != 0);
      jump = ($urandom_range(0, 7) == 0);
      upd_valid = ($urandom_range(0, 1) == 1);
      upd_pc = ($urandom_range(0, 3) << 8) | ($urandom_range(0, 7) << 2) | $urandom_range(0, 3);
      upd_taken = ($urandom_range(0, 2) != 0);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
